// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: one-hot state indices,
// the state encoding built from them, and the gnt_id width helper.
package rr_arbiter_defs;

    localparam int ST_IDLE    = 0;
    localparam int ST_GRANT   = 1;
    localparam int ST_RELEASE = 2;
    localparam int ST_COUNT   = 3;

    // One-hot state encoding; each state's bit position is its index above.
    typedef enum logic [ST_COUNT-1:0] {
        S_IDLE    = 3'(1 << ST_IDLE),
        S_GRANT   = 3'(1 << ST_GRANT),
        S_RELEASE = 3'(1 << ST_RELEASE)
    } state_t;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin winner selection. The request vector
// is rotated so that index last+1 lands at bit 0, the lowest set bit of the
// rotated vector is found, and its position is mapped back to a requester
// index modulo N.
module rr_pick
    import rr_arbiter_defs::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic           w_found;

    // Two copies side by side make a right shift behave as a rotation.
    assign w_dbl   = {i_req, i_req};
    assign w_shift = w_dbl >> (int'(i_last) + 1);
    assign w_rot   = w_shift[N-1:0];

    // Priority-encode the rotated vector and map the hit back to an index.
    always_comb begin
        w_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                o_idx   = IW'((int'(i_last) + 1 + k) % N);
            end
        end
        if (w_found) begin
            o_onehot = N'(1) << o_idx;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one shared sequential resource.
// Grants one requester at a time, holds the grant until done or until the
// owner drops its request, then inserts a one-cycle release bubble.
// Optional feature macro: RR_ARB_TIMEOUT_EN adds a hold counter that forces
// a release after HOLD_MAX grant cycles and pulses the timeout output.
module rr_arbiter
    import rr_arbiter_defs::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [N-1:0]             req,
    input  logic                     done,
    output logic [N-1:0]             gnt,
    output logic [id_width(N)-1:0]   gnt_id,
    output logic                     busy
`ifdef RR_ARB_TIMEOUT_EN
   ,output logic                     timeout
`endif
);

    localparam int IW = id_width(N);

    // Reject unsupported configurations at elaboration.
    if (N < 2 || N > 8 || HOLD_MAX < 1) begin : g_bad_param
        $error("rr_arbiter: N must be 2..8 and HOLD_MAX at least 1");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] w_gnt_id_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_last_nxt;

    logic [N-1:0]  w_pick_oh;
    logic [IW-1:0] w_pick_idx;
    logic          w_req_any;
    logic          w_owner_req;
    logic          w_release;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          w_expire;

    assign w_expire = (r_hold == HW'(HOLD_MAX - 1));
    assign timeout  = r_timeout;
`endif

    // The pointer register already holds the previous owner while in
    // RELEASE, so the same pick serves both IDLE and RELEASE.
    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    assign w_req_any   = |req;
    assign w_owner_req = |(req & r_gnt);
    assign w_release   = done || !w_owner_req;

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_busy_nxt   = r_busy;
        w_last_nxt   = r_last;
`ifdef RR_ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_RELEASE: begin
                if (w_req_any) begin
                    w_state_nxt  = S_GRANT;
                    w_gnt_nxt    = w_pick_oh;
                    w_gnt_id_nxt = w_pick_idx;
                    w_busy_nxt   = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    w_hold_nxt   = '0;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
                w_hold_nxt = r_hold + 1'b1;
                if (w_release || w_expire) begin
                    w_state_nxt   = S_RELEASE;
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_last_nxt    = r_gnt_id;
                    // A normal release in the expiry cycle suppresses the pulse.
                    w_timeout_nxt = w_expire && !w_release;
                end
`else
                if (w_release) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = r_gnt_id;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_last   <= IW'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
            r_last   <= w_last_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

endmodule
